// File: rtl/pim_seq_pkg.sv
// Shared types and constants for the PIM register-file sequencer.
package pim_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    EXEC,
    UPDATE,
    MOV,
    MOV_WAIT
  } state_t;

  localparam int UPD_DEST = 0;
  localparam int UPD_SRC1 = 1;
  localparam int UPD_SRC2 = 2;
  localparam int UPD_IW1  = 3;
  localparam int UPD_IW2  = 4;
  localparam int UPD_IMM  = 5;

  localparam logic [3:0] CW_MOV = 4'b0001;
  localparam logic [3:0] CW_NOP = 4'b0000;

endpackage

// File: rtl/exec_watchdog.sv
// Counts EXEC cycles and flags the last cycle the crossbar is allowed to take.
module exec_watchdog #(
  parameter int EXEC_TIMEOUT = 1024,
  parameter int CNT_W        = 11
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + CNT_W'(1);
  end

  assign expire = en && (cnt == CNT_W'(EXEC_TIMEOUT - 1));

endmodule

// File: rtl/pim_regfile_sequencer.sv
// Sequences register-file load, crossbar execution and base-register updates
// for one PIM instruction or register MOV per handshake.
module pim_regfile_sequencer
  import pim_seq_pkg::*;
#(
  parameter int INSTR_W      = 64,
  parameter int EXEC_TIMEOUT = 1024,
  parameter int CNT_W        = 11
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [INSTR_W-1:0] instr_data,
  input  logic               instr_is_mov,
  input  logic [5:0]         instr_upd_mask,
  input  logic [3:0]         mov_src_in,
  input  logic [3:0]         mov_dest_in,
  output logic [INSTR_W-1:0] PIM_instr,
  output logic               PIM_load,
  output logic [3:0]         CW_opcode,
  output logic [3:0]         mov_src_bin,
  output logic [3:0]         mov_dest_bin,
  output logic               ubr_dest,
  output logic               ubr_src1,
  output logic               ubr_src2,
  output logic               ubr_iw1,
  output logic               ubr_iw2,
  output logic               sri_imm,
  output logic               exec_start,
  input  logic               exec_done,
  output logic               busy,
  output logic               timeout_err
);

  state_t     state, state_n;
  logic [5:0] mask;
  logic       accept, expire, to_hit, upd;

  exec_watchdog #(.EXEC_TIMEOUT(EXEC_TIMEOUT), .CNT_W(CNT_W)) u_wdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (state == LOAD),
    .en     (state == EXEC),
    .expire (expire)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    accept  = (state == IDLE) && instr_valid && instr_ready;
    to_hit  = 1'b0;
    case (state)
      IDLE:     if (accept) state_n = instr_is_mov ? MOV : LOAD;
      LOAD:     state_n = EXEC;
      // exec_done takes priority over a same-cycle watchdog expiry
      EXEC: begin
        if (exec_done) state_n = UPDATE;
        else if (expire) begin
          state_n = IDLE;
          to_hit  = 1'b1;
        end
      end
      UPDATE:   state_n = IDLE;
      MOV:      state_n = MOV_WAIT;
      MOV_WAIT: state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  assign upd = (state_n == UPDATE);

  // Outputs are decoded from the next state so every strobe is a flop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instr_ready  <= 1'b0;
      busy         <= 1'b0;
      PIM_load     <= 1'b0;
      exec_start   <= 1'b0;
      CW_opcode    <= CW_NOP;
      ubr_dest     <= 1'b0;
      ubr_src1     <= 1'b0;
      ubr_src2     <= 1'b0;
      ubr_iw1      <= 1'b0;
      ubr_iw2      <= 1'b0;
      sri_imm      <= 1'b0;
      timeout_err  <= 1'b0;
      PIM_instr    <= '0;
      mask         <= '0;
      mov_src_bin  <= '0;
      mov_dest_bin <= '0;
    end else begin
      instr_ready <= (state_n == IDLE);
      busy        <= (state_n != IDLE);
      PIM_load    <= (state_n == LOAD);
      exec_start  <= (state == LOAD);
      CW_opcode   <= (state_n == MOV) ? CW_MOV : CW_NOP;
      ubr_dest    <= upd & mask[UPD_DEST];
      ubr_src1    <= upd & mask[UPD_SRC1];
      ubr_src2    <= upd & mask[UPD_SRC2];
      ubr_iw1     <= upd & mask[UPD_IW1];
      ubr_iw2     <= upd & mask[UPD_IW2];
      sri_imm     <= upd & mask[UPD_IMM];
      if (to_hit) timeout_err <= 1'b1;
      if (accept) begin
        PIM_instr <= instr_data;
        mask      <= instr_upd_mask;
        if (instr_is_mov) begin
          mov_src_bin  <= mov_src_in;
          mov_dest_bin <= mov_dest_in;
        end
      end
    end
  end

endmodule

// File: tb/tb_pim_regfile_sequencer.sv
// Scoreboard bench: stimulus queues expected strobe events with their cycle,
// a negedge monitor pops and compares each event the DUT produces.
module tb_pim_regfile_sequencer;

  localparam int EV_LOAD = 1, EV_START = 2, EV_UPD = 3, EV_MOV = 4, EV_TO = 5;

  typedef struct {
    int          kind;
    logic [63:0] pay;
    int          cyc;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n, instr_valid, instr_is_mov, exec_done;
  logic [63:0] instr_data;
  logic [5:0]  instr_upd_mask;
  logic [3:0]  mov_src_in, mov_dest_in;
  logic        instr_ready, PIM_load, exec_start, busy, timeout_err;
  logic [63:0] PIM_instr;
  logic [3:0]  CW_opcode, mov_src_bin, mov_dest_bin;
  logic        ubr_dest, ubr_src1, ubr_src2, ubr_iw1, ubr_iw2, sri_imm;

  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  ev_t q[$];
  logic to_prev = 1'b0;

  pim_regfile_sequencer #(.INSTR_W(64), .EXEC_TIMEOUT(8), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_data(instr_data), .instr_is_mov(instr_is_mov), .instr_upd_mask(instr_upd_mask),
    .mov_src_in(mov_src_in), .mov_dest_in(mov_dest_in), .PIM_instr(PIM_instr),
    .PIM_load(PIM_load), .CW_opcode(CW_opcode), .mov_src_bin(mov_src_bin),
    .mov_dest_bin(mov_dest_bin), .ubr_dest(ubr_dest), .ubr_src1(ubr_src1),
    .ubr_src2(ubr_src2), .ubr_iw1(ubr_iw1), .ubr_iw2(ubr_iw2), .sri_imm(sri_imm),
    .exec_start(exec_start), .exec_done(exec_done), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input logic [63:0] pay, input int c);
    ev_t e;
    e.kind = kind; e.pay = pay; e.cyc = c;
    q.push_back(e);
  endtask

  task automatic observe(input int kind, input logic [63:0] pay);
    ev_t e;
    if (q.size() == 0) begin
      checks++; errors++;
      $display("FAIL unexpected_event: got kind %0d payload %0h expected none (cycle %0d)", kind, pay, cyc);
    end else begin
      e = q.pop_front();
      chk("event_kind", 64'(kind), 64'(e.kind));
      chk("event_payload", pay, e.pay);
      chk("event_cycle", 64'(cyc), 64'(e.cyc));
    end
  endtask

  // Monitor: every active strobe or a rising timeout flag is an event.
  always @(negedge clk) begin
    int n;
    if (cyc > 0) begin
      n = 0;
      if (PIM_load === 1'b1) begin n++; observe(EV_LOAD, PIM_instr); end
      if (exec_start === 1'b1) begin n++; observe(EV_START, 64'd0); end
      if ({sri_imm, ubr_iw2, ubr_iw1, ubr_src2, ubr_src1, ubr_dest} !== 6'b0) begin
        n++;
        observe(EV_UPD, {58'd0, sri_imm, ubr_iw2, ubr_iw1, ubr_src2, ubr_src1, ubr_dest});
      end
      if (CW_opcode !== 4'b0) begin n++; observe(EV_MOV, {52'd0, CW_opcode, mov_src_bin, mov_dest_bin}); end
      if (timeout_err === 1'b1 && to_prev !== 1'b1) observe(EV_TO, 64'd0);
      to_prev = timeout_err;
      chk("strobe_overlap", 64'(n <= 1), 64'd1);
    end
  end

  task automatic issue(input logic mov, input logic [63:0] d, input logic [5:0] m,
                       input logic [3:0] s, input logic [3:0] dd, output int acc);
    int w = 0;
    instr_valid = 1'b1; instr_is_mov = mov; instr_data = d;
    instr_upd_mask = m; mov_src_in = s; mov_dest_in = dd;
    while (instr_ready !== 1'b1 && w < 50) begin @(negedge clk); w++; end
    if (w >= 50) begin
      checks++; errors++;
      $display("FAIL ready_wait: got instr_ready=%b expected 1 within 50 cycles", instr_ready);
    end
    acc = cyc + 1;
    if (mov) push(EV_MOV, {52'd0, 4'b0001, s, dd}, acc);
    else begin
      push(EV_LOAD, d, acc);
      push(EV_START, 64'd0, acc + 1);
    end
    @(negedge clk);
    instr_valid = 1'b0;
  endtask

  // Pulse exec_done dly cycles after the exec_start cycle.
  task automatic finish_exec(input int acc, input int dly, input logic [5:0] m);
    while (cyc < acc + 1 + dly) @(negedge clk);
    exec_done = 1'b1;
    if (m != 6'd0) push(EV_UPD, {58'd0, m}, cyc + 1);
    @(negedge clk);
    exec_done = 1'b0;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int acc, a1, a2, a3;
    rst_n = 1'b0; instr_valid = 1'b1; instr_is_mov = 1'b0; exec_done = 1'b0;
    instr_data = 64'h55; instr_upd_mask = 6'h3f; mov_src_in = 4'd1; mov_dest_in = 4'd2;

    // 1: reset with valid held high
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(instr_ready), 64'd0);
    chk("rst_load", 64'(PIM_load), 64'd0);
    chk("rst_start", 64'(exec_start), 64'd0);
    chk("rst_cw", 64'(CW_opcode), 64'd0);
    chk("rst_ubr", 64'({sri_imm, ubr_iw2, ubr_iw1, ubr_src2, ubr_src1, ubr_dest}), 64'd0);
    chk("rst_instr", PIM_instr, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_timeout", 64'(timeout_err), 64'd0);
    instr_valid = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 64'(instr_ready), 64'd1);

    // 2: PIM instruction, exec_done 5 cycles after exec_start
    issue(1'b0, 64'h0000_0000_0001_2343, 6'b000011, 4'd0, 4'd0, acc);
    chk("load_busy", 64'(busy), 64'd1);
    finish_exec(acc, 5, 6'b000011);
    chk("ready_upd_cycle", 64'(instr_ready), 64'd0);
    @(negedge clk);
    chk("ready_after_done", 64'(instr_ready), 64'd1);
    chk("pim_instr_hold", PIM_instr, 64'h0000_0000_0001_2343);

    // 3: back-to-back MOVs, including src==dest and dest=15
    issue(1'b1, 64'hA, 6'd0, 4'd3, 4'd9, a1);
    issue(1'b1, 64'hB, 6'd0, 4'd4, 4'd15, a2);
    issue(1'b1, 64'hC, 6'd0, 4'd7, 4'd7, a3);
    chk("mov_throughput_1", 64'(a2 - a1), 64'd3);
    chk("mov_throughput_2", 64'(a3 - a2), 64'd3);
    wait_cyc(a3 + 3);
    chk("mov_ready", 64'(instr_ready), 64'd1);
    chk("mov_src_hold", 64'(mov_src_bin), 64'd7);

    // 5: exec_done on the watchdog expiry cycle, then stray exec_done in IDLE
    issue(1'b0, 64'hDEAD_BEEF_0000_0005, 6'b111100, 4'd0, 4'd0, acc);
    finish_exec(acc, 7, 6'b111100);
    chk("done_wins_err", 64'(timeout_err), 64'd0);
    @(negedge clk);
    chk("done_wins_ready", 64'(instr_ready), 64'd1);
    exec_done = 1'b1;
    repeat (3) @(negedge clk);
    exec_done = 1'b0;
    chk("stray_done_busy", 64'(busy), 64'd0);
    chk("stray_done_ready", 64'(instr_ready), 64'd1);

    // 4: watchdog timeout, then a normal instruction with mask 0
    issue(1'b0, 64'h0123_4567_89AB_CDEF, 6'b010101, 4'd0, 4'd0, acc);
    push(EV_TO, 64'd0, acc + 9);
    wait_cyc(acc + 8);
    chk("to_not_yet", 64'(timeout_err), 64'd0);
    @(negedge clk);
    chk("to_flag", 64'(timeout_err), 64'd1);
    chk("to_ready", 64'(instr_ready), 64'd1);
    issue(1'b0, 64'h77, 6'b000000, 4'd0, 4'd0, acc);
    finish_exec(acc, 2, 6'b000000);
    chk("mask0_ready_low", 64'(instr_ready), 64'd0);
    @(negedge clk);
    chk("mask0_ready", 64'(instr_ready), 64'd1);
    chk("to_sticky", 64'(timeout_err), 64'd1);

    // 6: valid held high while busy, then reset mid-EXEC
    issue(1'b0, 64'hCAFE_0006, 6'b111111, 4'd0, 4'd0, acc);
    instr_valid = 1'b1; instr_data = 64'hBAD;
    chk("hold_ready_load", 64'(instr_ready), 64'd0);
    wait_cyc(acc + 3);
    chk("hold_ready_exec", 64'(instr_ready), 64'd0);
    chk("hold_instr", PIM_instr, 64'hCAFE_0006);
    rst_n = 1'b0;
    @(negedge clk);
    instr_valid = 1'b0;
    chk("midrst_ready", 64'(instr_ready), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_to", 64'(timeout_err), 64'd0);
    chk("midrst_instr", PIM_instr, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("post_rst_ready", 64'(instr_ready), 64'd1);
    chk("pending_events", 64'(q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
